ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Fetch/exec/writeback sequencer: 3 cycles per instruction (FETCH with same-cycle ack, EXEC, WB); FETCH stalls until imem_ack.
// Optional single-step mode: define CTRL_STEP_EN to add the step port and the PAUSE state after WB.
module ctrl_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic [7:0]  f,
  input  logic        ovf,
  input  logic        take_branch,
  output logic [1:0]  rd0_addr,
  output logic [1:0]  rd1_addr,
  output logic [7:0]  instr_i,
  output logic [2:0]  alu_op,
  output logic        alu_s0,
  output logic        alu_s1,
  output logic        wr_en,
  output logic [1:0]  wr_addr,
  output logic [8:0]  wr_data,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        illegal
`ifdef CTRL_STEP_EN
  ,
  input  logic        step
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
`ifdef CTRL_STEP_EN
    ,
    S_PAUSE = 3'd5
`endif
  } state_t;

  state_t      r_state;
  logic [15:0] r_ir;
  logic [7:0]  r_pc;
  logic [8:0]  r_wr_data;
  logic        r_wr_en;
  logic        r_imem_req;
  logic        r_busy;
  logic        r_halted;
  logic        r_illegal;
  logic        r_take;

  logic [3:0]  w_op;
  logic [1:0]  w_dst;
  logic [1:0]  w_src;
  logic [7:0]  w_imm;
  logic        w_writes;
  logic        w_ctl_en;
  logic [7:0]  w_pc_inc;

  assign w_op     = r_ir[15:12];
  assign w_dst    = r_ir[11:10];
  assign w_src    = r_ir[9:8];
  assign w_imm    = r_ir[7:0];
  assign w_writes = (w_op == 4'h1) || (w_op == 4'h2) || w_op[3];
  assign w_ctl_en = (r_state == S_EXEC) || (r_state == S_WB);
  assign w_pc_inc = r_pc + 8'd1;

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign wr_en     = r_wr_en;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

  // Datapath controls decode straight from the instruction register and are held through EXEC and WB.
  always_comb begin
    rd0_addr = 2'b00;
    rd1_addr = 2'b00;
    instr_i  = 8'h00;
    alu_op   = 3'b000;
    alu_s0   = 1'b0;
    alu_s1   = 1'b0;
    wr_addr  = 2'b00;
    if (w_ctl_en) begin
      instr_i = w_imm;
      wr_addr = w_dst;
      if (w_op[3]) begin
        rd0_addr = w_dst;
        rd1_addr = w_src;
        alu_op   = w_op[2:0];
      end else begin
        case (w_op)
          4'h1: begin
            alu_s0 = 1'b1;
            alu_s1 = 1'b1;
          end
          4'h2: begin
            rd0_addr = w_dst;
            alu_s1   = 1'b1;
          end
          4'h3: begin
            rd0_addr = w_dst;
            rd1_addr = w_src;
            alu_op   = 3'b111;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ir       <= 16'h0000;
      r_pc       <= 8'h00;
      r_wr_data  <= 9'h000;
      r_wr_en    <= 1'b0;
      r_imem_req <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
      r_take     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_ir       <= imem_data;
            r_imem_req <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wr_data <= {ovf, f};
          r_take    <= take_branch;
          if ((w_op == 4'h5) || (w_op == 4'h6)) begin
            r_illegal <= 1'b1;
          end
          if (w_op == 4'h7) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_state <= S_WB;
            r_wr_en <= w_writes;
          end
        end
        S_WB: begin
          r_wr_en <= 1'b0;
          if ((w_op == 4'h4) || ((w_op == 4'h3) && r_take)) begin
            r_pc <= w_imm;
          end else begin
            r_pc <= w_pc_inc;
          end
`ifdef CTRL_STEP_EN
          r_state <= S_PAUSE;
`else
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
`endif
        end
`ifdef CTRL_STEP_EN
        S_PAUSE: begin
          if (step) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
`endif
        S_HALT: ;
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_wr_en    <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed and randomized instruction streams for ctrl_sequencer, checked against an opcode-table reference model.
module tb_ctrl_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [7:0]  f;
  logic        ovf;
  logic        take_branch;
  logic [1:0]  rd0_addr;
  logic [1:0]  rd1_addr;
  logic [7:0]  instr_i;
  logic [2:0]  alu_op;
  logic        alu_s0;
  logic        alu_s1;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [8:0]  wr_data;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic        illegal;
`ifdef CTRL_STEP_EN
  logic        step;
`endif

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .f(f), .ovf(ovf), .take_branch(take_branch),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .instr_i(instr_i),
    .alu_op(alu_op), .alu_s0(alu_s0), .alu_s1(alu_s1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
`ifdef CTRL_STEP_EN
    , .step(step)
`endif
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] m_pc;
  logic       m_illegal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: what each opcode is defined to do, as plain lookups.
  function automatic bit m_writes(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op >= 4'h8);
  endfunction
  function automatic bit m_has_alu(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h2) || (op == 4'h3) || (op >= 4'h8);
  endfunction
  function automatic logic [2:0] m_alu(input logic [3:0] op);
    if (op >= 4'h8) return op[2:0];
    if (op == 4'h3) return 3'b111;
    return 3'b000;
  endfunction
  function automatic logic [7:0] m_next_pc(input logic [3:0] op, input logic [7:0] cur,
                                           input logic [7:0] imm, input logic tk);
    int nxt;
    nxt = (int'(cur) + 1) % 256;
    if (op == 4'h4) nxt = int'(imm);
    if ((op == 4'h3) && tk) nxt = int'(imm);
    return nxt[7:0];
  endfunction

  function automatic logic [31:0] ctl_vec();
    return 32'({alu_op, alu_s0, alu_s1, rd0_addr, rd1_addr, instr_i, wr_en});
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "_req"},    32'(imem_req), 32'd0);
    check({tag, "_busy"},   32'(busy),     32'd0);
    check({tag, "_halted"}, 32'(halted),   32'd0);
    check({tag, "_illegal"},32'(illegal),  32'd0);
    check({tag, "_pc"},     32'(pc),       32'd0);
    check({tag, "_wrdata"}, 32'(wr_data),  32'd0);
    check({tag, "_ctl"},    ctl_vec(),     32'd0);
  endtask

  task automatic wait_fetch();
    for (int k = 0; k < 20 && imem_req !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    check("fetch_reached", 32'(imem_req), 32'd1);
  endtask

  // Caller leaves the DUT in FETCH at posedge+1; returns at posedge+1 in the next FETCH (or HALT).
  task automatic run_instr(input logic [15:0] ins, input int dly, input logic [7:0] fv,
                           input logic ov, input logic tk);
    logic [3:0] op;
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] imm;
    op = ins[15:12]; dst = ins[11:10]; src = ins[9:8]; imm = ins[7:0];
    wait_fetch();
    check("fetch_addr", 32'(imem_addr), 32'(m_pc));
    for (int k = 0; k < dly; k++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", 32'(imem_addr), 32'(m_pc));
      check("no_ctl_before_ack", ctl_vec(), 32'd0);
      @(posedge clk); #1;
    end
    imem_ack = 1'b1; imem_data = ins;
    @(negedge clk);
    check("req_on_ack", 32'(imem_req), 32'd1);
    check("ctl_on_ack", ctl_vec(), 32'd0);
    @(posedge clk); #1;
    imem_data = 16'($urandom); f = fv; ovf = ov; take_branch = tk;
    @(negedge clk);
    check("exec_imm", 32'(instr_i), 32'(imm));
    if (m_has_alu(op)) begin
      check("exec_alu_op", 32'(alu_op), 32'(m_alu(op)));
      check("exec_s0", 32'(alu_s0), 32'(op == 4'h1));
      check("exec_s1", 32'(alu_s1), 32'((op == 4'h1) || (op == 4'h2)));
    end
    if ((op == 4'h2) || (op == 4'h3) || (op >= 4'h8)) check("exec_rd0", 32'(rd0_addr), 32'(dst));
    if ((op == 4'h3) || (op >= 4'h8)) check("exec_rd1", 32'(rd1_addr), 32'(src));
    check("exec_wr_en", 32'(wr_en), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    f = 8'($urandom); ovf = 1'($urandom); take_branch = 1'($urandom);
    if ((op == 4'h5) || (op == 4'h6)) m_illegal = 1'b1;
    if (op == 4'h7) begin
      imem_ack = 1'b0;
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_busy", 32'(busy), 32'd0);
      check("halt_pc", 32'(pc), 32'(m_pc));
      check("halt_req", 32'(imem_req), 32'd0);
    end else begin
      @(negedge clk);
      check("wb_wr_en", 32'(wr_en), 32'(m_writes(op)));
      if (m_writes(op)) begin
        check("wb_wr_addr", 32'(wr_addr), 32'(dst));
        check("wb_wr_data", 32'(wr_data), 32'({ov, fv}));
      end
      check("illegal_flag", 32'(illegal), 32'(m_illegal));
      @(posedge clk); #1;
      imem_ack = 1'b0;
      m_pc = m_next_pc(op, m_pc, imm, tk);
      check("pc_after_wb", 32'(pc), 32'(m_pc));
      check("wr_en_pulse_end", 32'(wr_en), 32'd0);
`ifdef CTRL_STEP_EN
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("pause_req", 32'(imem_req), 32'd0);
        check("pause_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
      end
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
`endif
    end
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
    f = 8'h00; ovf = 1'b0; take_branch = 1'b0;
`ifdef CTRL_STEP_EN
    step = 1'b0;
`endif
    m_pc = 8'h00; m_illegal = 1'b0;
    #3;
    check_cleared("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_wait_busy", 32'(busy), 32'd0);
      check("idle_wait_req", 32'(imem_req), 32'd0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    run_instr(16'h142A, 0, 8'h2A, 1'b0, 1'b0);
    check("ldi_pc", 32'(pc), 32'd1);
    run_instr({8'h28, 8'($urandom)}, 4, 8'($urandom), 1'($urandom), 1'b0);
    run_instr({8'h28, 8'($urandom)}, 0, 8'($urandom), 1'($urandom), 1'b0);
    run_instr(16'h3640, 1, 8'h00, 1'b0, 1'b1);
    check("br_taken_pc", 32'(pc), 32'h40);
    run_instr(16'h3640, 0, 8'h00, 1'b0, 1'b0);
    check("br_not_taken_pc", 32'(pc), 32'h41);
    run_instr(16'h40FF, 0, 8'h00, 1'b0, 1'b0);
    check("jmp_pc", 32'(pc), 32'hFF);
    run_instr(16'h0000, 2, 8'h00, 1'b0, 1'b0);
    check("wrap_pc", 32'(pc), 32'h00);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h7) op = 4'h0;
      run_instr({op, 12'($urandom)}, int'($urandom_range(0, 3)), 8'($urandom),
                1'($urandom), 1'($urandom));
    end

    run_instr(16'h5123, 0, 8'h00, 1'b0, 1'b0);
    check("illegal_set", 32'(illegal), 32'd1);
    run_instr(16'h7000, 1, 8'h00, 1'b0, 1'b0);
    repeat (3) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("halt_hold", 32'(halted), 32'd1);
      check("halt_hold_busy", 32'(busy), 32'd0);
      check("halt_hold_req", 32'(imem_req), 32'd0);
      check("halt_hold_pc", 32'(pc), 32'(m_pc));
      check("illegal_sticky", 32'(illegal), 32'd1);
    end
    #2 rst = 1'b0;
    #1 check_cleared("async_reset");

    // Reset while fetching drops imem_req without waiting for a clock edge.
    @(posedge clk); #1 rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("refetch_req", 32'(imem_req), 32'd1);
    #2 rst = 1'b0;
    #1 check("midfetch_req_drop", 32'(imem_req), 32'd0);

    // Reset during WB abandons the write.
    @(posedge clk); #1 rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    imem_ack = 1'b1; imem_data = 16'h1C55;
    f = 8'h55; ovf = 1'b1;
    @(posedge clk); #1 imem_ack = 1'b0;
    @(posedge clk); #1;
    check("wb_before_reset", 32'(wr_en), 32'd1);
    #2 rst = 1'b0;
    #1 check("wb_abandon_wr_en", 32'(wr_en), 32'd0);
    check_cleared("wb_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
